multi_cycle_ctrl: RTL

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl_pkg.sv | 132 +++++++++++++
 rtl/multi_cycle_ctrl_alu_op_decode.sv | 31 +++
 rtl/multi_cycle_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle control path: opcodes, functs,
// FSM state codes, ALU/PC selects and the per-state control bundle.
package multi_cycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ASB_REG  = 2'b00;
  localparam logic [1:0] ASB_FOUR = 2'b01;
  localparam logic [1:0] ASB_IMM  = 2'b10;
  localparam logic [1:0] ASB_IMM2 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_HALT     = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_GTZ = 3'd5
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_ALU  = 2'b00,
    PC_JUMP = 2'b01,
    PC_BEQ  = 2'b10,
    PC_BGTZ = 2'b11
  } pc_src_t;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    pc_src_t    pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
  } ctrl_t;

  function automatic logic op_legal(logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW ||
           op == OP_SW    || op == OP_BEQ ||
           op == OP_BGTZ  || op == OP_J ||
           op == OP_ADDI;
  endfunction

  // Opcode only matters for BRANCH, where it picks the target mux.
  function automatic ctrl_t ctrl_for(state_t s,
                                     logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = ASB_FOUR;
        c.pc_write  = 1'b1;
      end
      S_DECODE:   c.alu_src_b = ASB_IMM2;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ASB_IMM;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC:     c.alu_src_a = 1'b1;
      S_ALU_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.branch    = 1'b1;
        c.alu_src_a = 1'b1;
        c.pc_src    = (op == OP_BGTZ) ? PC_BGTZ
                                      : PC_BEQ;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_JUMP;
      end
      S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ASB_IMM;
      end
      S_ADDI_WB:  c.reg_write = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_alu_op_decode.sv
// ALU operation decode: funct-driven in EXEC, opcode-driven in BRANCH,
// plain add everywhere else; flags unsupported functs in EXEC.
module alu_op_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_t    alu_op,
  output logic       bad_funct
);

  always_comb begin
    alu_op    = ALU_ADD;
    bad_funct = 1'b0;
    if (state == S_EXEC) begin
      case (funct)
        FN_ADD:  alu_op = ALU_ADD;
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: bad_funct = 1'b1;
      endcase
    end else if (state == S_BRANCH) begin
      alu_op = (opcode == OP_BGTZ) ? ALU_GTZ
                                   : ALU_SUB;
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control FSM with registered Moore controls;
// alu_op and the illegal pulse come from the current state decode.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       pc_write,
  output logic       branch,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  state_t  cur, nxt;
  ctrl_t   ctrl_q, ctrl_o;
  alu_op_t dec_op;
  logic    bad_funct, bad_op, trap;

  alu_op_decode u_dec (
    .state     (cur),
    .opcode    (opcode),
    .funct     (funct),
    .alu_op    (dec_op),
    .bad_funct (bad_funct)
  );

  assign bad_op = (cur == S_DECODE) && !op_legal(opcode);
  assign trap   = bad_op | bad_funct;

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:    nxt = S_MEM_ADDR;
          OP_RTYPE:        nxt = S_EXEC;
          OP_BEQ, OP_BGTZ: nxt = S_BRANCH;
          OP_J:            nxt = S_JUMP;
          OP_ADDI:         nxt = S_ADDI_EX;
          default:         nxt = S_FETCH;
        endcase
      end
      S_MEM_ADDR:
        nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  nxt = S_MEM_WB;
      S_EXEC:    nxt = S_ALU_WB;
      S_ADDI_EX: nxt = S_ADDI_WB;
      S_HALT:    nxt = S_HALT;
      default:   nxt = S_FETCH;
    endcase
    if (trap)
      nxt = ILLEGAL_TRAP ? S_HALT : S_FETCH;
  end

  // Controls are preloaded with the target state's values so they are
  // valid for the whole state; FETCH values wait behind rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= S_FETCH;
      ctrl_q <= ctrl_for(S_FETCH, OP_RTYPE);
    end else begin
      cur    <= nxt;
      ctrl_q <= ctrl_for(nxt, opcode);
    end
  end

  assign ctrl_o     = rst_n ? ctrl_q : '0;
  assign pc_write   = ctrl_o.pc_write;
  assign branch     = ctrl_o.branch;
  assign pc_src     = ctrl_o.pc_src;
  assign ir_write   = ctrl_o.ir_write;
  assign mem_read   = ctrl_o.mem_read;
  assign mem_write  = ctrl_o.mem_write;
  assign i_or_d     = ctrl_o.i_or_d;
  assign reg_write  = ctrl_o.reg_write;
  assign reg_dst    = ctrl_o.reg_dst;
  assign mem_to_reg = ctrl_o.mem_to_reg;
  assign alu_src_a  = ctrl_o.alu_src_a;
  assign alu_src_b  = ctrl_o.alu_src_b;
  assign alu_op     = dec_op;
  assign illegal    = rst_n & trap;
  assign state      = cur;

endmodule
